// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard and stall control.
// Drives the data-hazard stall, the memory-wait global freeze and the
// branch flush, and keeps saturating counters for stall and freeze cycles.
// Optional feature: define FORWARDING_EN so that only load-use hazards stall.
// Without it, any EXE or MEM write-back to a source register stalls.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src_1,
    input  logic [3:0]       src_2,
    input  logic             two_src,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             hazard_stall,
    output logic             freeze_all,
    output logic             flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] freeze_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

    localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    state_t           cur_state;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] freeze_q, freeze_d;
    logic             match_exe;
    logic             match_mem;
    logic             stall_raw;

    // Source-register comparison against the EXE and MEM destinations
    always_comb begin
        match_exe = (src_1 == exe_dest) || (two_src && (src_2 == exe_dest));
        match_mem = (src_1 == mem_dest) || (two_src && (src_2 == mem_dest));
    end

`ifdef FORWARDING_EN
    // MEM-stage producers are covered by forwarding, so their ports only feed this sink.
    logic unused_mem;
    assign unused_mem = ^{mem_wb_en, match_mem};

    // Load-use is the only hazard forwarding cannot resolve
    always_comb begin
        stall_raw = exe_mem_r_en && exe_wb_en && match_exe;
    end
`else
    logic unused_load;
    assign unused_load = exe_mem_r_en;

    // Without forwarding, any in-flight write-back to a source must stall
    always_comb begin
        stall_raw = (exe_wb_en && match_exe) || (mem_wb_en && match_mem);
    end
`endif

    // Next-state, flush-counter and priority-resolved control outputs.
    // While rst is high the decode treats the machine as already in RUN.
    always_comb begin
        freeze_all = mem_req && !mem_ready;
        cur_state  = rst ? ST_RUN : state_q;
        state_d    = cur_state;
        fcnt_d     = fcnt_q;
        flush      = 1'b0;
        case (cur_state)
            ST_RUN: begin
                if (freeze_all) begin
                    state_d = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FCNT_LOAD;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!freeze_all) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!freeze_all) begin
                    flush = 1'b1;
                    if (fcnt_q == 2'd1) begin
                        state_d = ST_RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        endcase
        hazard_stall = stall_raw && !freeze_all && !flush;
    end

    // Saturating statistics counters
    always_comb begin
        stall_d  = stall_q;
        freeze_d = freeze_q;
        if (hazard_stall && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (freeze_all && (freeze_q != '1)) begin
            freeze_d = freeze_q + 1'b1;
        end
    end

    // State and counter registers; reset abandons any wait or flush in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            fcnt_q   <= '0;
            stall_q  <= '0;
            freeze_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            stall_q  <= stall_d;
            freeze_q <= freeze_d;
        end
    end

    assign state        = state_q;
    assign stall_count  = stall_q;
    assign freeze_count = freeze_q;

endmodule
